calc_driver: RTL and testbench

CALC_DRIVER -- requirements
Module: calc_driver

---
 rtl/calc_driver.sv | 132 +++++++++++++
 tb/tb_calc_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_driver.sv
// Sequences queued ALU commands onto the calculator's button/switch inputs and
// captures each result from its LEDs, with a collapsible accumulator-clear request.
module calc_driver #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     btnu,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [15:0]              cmd_operand,
  input  logic                     clr_req,
  input  logic [15:0]              led_in,
  output logic                     out_btnl,
  output logic                     out_btnc,
  output logic                     out_btnr,
  output logic                     out_btnd,
  output logic                     out_btnu,
  output logic [15:0]              out_sw,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [15:0]              res_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned MAXC = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    StIdle, StClear, StSetup, StStrobe, StHold, StCapture, StResult
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clr_pend_q, clr_pend_d;
  logic [18:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            push, pop, clr_eff;
  logic [18:0]     head;

  // DEPTH is a power of two, so the MSB of the count is set only when full.
  assign cmd_ready  = ~count_q[PW];
  assign fifo_count = count_q;
  assign push       = cmd_valid & cmd_ready & ~btnu;
  assign head       = mem[rd_ptr_q];
  assign clr_eff    = clr_pend_q | clr_req;
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q | clr_req;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_eff) begin
          state_d    = StClear;
          clr_pend_d = 1'b0;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StClear: state_d = StIdle;
      StSetup: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) state_d = StStrobe;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      StStrobe: begin
        state_d = StHold;
        cnt_d   = '0;
      end
      StHold: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) state_d = StCapture;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      StCapture: state_d = StResult;
      StResult: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {cmd_op, cmd_operand};
  end

  always_ff @(posedge clk) begin
    if (btnu) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_btnl   <= 1'b0;
      out_btnc   <= 1'b0;
      out_btnr   <= 1'b0;
      out_btnd   <= 1'b0;
      out_btnu   <= 1'b0;
      out_sw     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (pop) {out_btnl, out_btnc, out_btnr, out_sw} <= head;
      // Strobes are registered off the next state so they track STROBE/CLEAR exactly.
      out_btnd <= (state_d == StStrobe);
      out_btnu <= (state_d == StClear);
      if (state_q == StCapture) begin
        res_data  <= led_in;
        res_valid <= 1'b1;
      end else if (state_q == StResult && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_driver.sv
// Self-checking bench for calc_driver: vector table plus scoreboard queues for
// strobed commands and captured results.
module tb_calc_driver;

  logic        clk = 1'b0;
  logic        btnu, cmd_valid, cmd_ready, clr_req, res_valid, res_ready, busy;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_operand, led_in, out_sw, res_data;
  logic        out_btnl, out_btnc, out_btnr, out_btnd, out_btnu;
  logic [2:0]  fifo_count;

  localparam logic [15:0] KEY = 16'h444C;  // 16'h1234 ^ KEY == 16'h5678

  calc_driver dut (
    .clk(clk), .btnu(btnu), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .clr_req(clr_req), .led_in(led_in),
    .out_btnl(out_btnl), .out_btnc(out_btnc), .out_btnr(out_btnr),
    .out_btnd(out_btnd), .out_btnu(out_btnu), .out_sw(out_sw),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Calculator stand-in: result is a fixed function of the operand presented.
  assign led_in = out_sw ^ KEY;

  int n_cmp = 0, n_err = 0, n_res = 0, n_btnd = 0, n_btnu = 0;
  logic [18:0] cmd_q[$];
  logic [15:0] res_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] opd;
    logic [2:0]  lcr;
    logic [15:0] res;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [15:0] opd);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      step(1);
      t++;
    end
    chk("push_ready", cmd_ready, 1);
    if (cmd_ready) begin
      cmd_op = op;
      cmd_operand = opd;
      cmd_valid = 1'b1;
      cmd_q.push_back({op, opd});
      res_q.push_back(opd ^ KEY);
      step(1);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rv(input logic val, input string name);
    int t = 0;
    while (res_valid !== val && t < 100) begin
      step(1);
      t++;
    end
    chk(name, res_valid, val);
  endtask

  task automatic wait_strobe(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_btnd && t < 60);
    chk(name, out_btnd, 1);
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    logic [18:0] e;
    chk("btnd_btnu_excl", out_btnd & out_btnu, 0);
    if (out_btnu) n_btnu++;
    if (out_btnd) begin
      n_btnd++;
      if (cmd_q.size() == 0) chk("strobe_unexpected", 1, 0);
      else begin
        e = cmd_q.pop_front();
        chk("strobe_op", {out_btnl, out_btnc, out_btnr}, e[18:16]);
        chk("strobe_sw", out_sw, e[15:0]);
        chk("strobe_busy", busy, 1);
      end
    end
    if (res_valid && res_ready) begin
      n_res++;
      if (res_q.size() == 0) chk("result_unexpected", 1, 0);
      else chk("result_data", res_data, res_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        bd[7];
    logic        rv[7];
    logic [15:0] held;
    int n0, nb0, nu0, t, rc, uc, dc, nu;

    vecs[0] = '{3'b100, 16'h0000, 3'b100, 16'h444C};
    vecs[1] = '{3'b111, 16'hFFFF, 3'b111, 16'hBBB3};
    vecs[2] = '{3'b000, 16'h444C, 3'b000, 16'h0000};
    vecs[3] = '{3'b101, 16'h8001, 3'b101, 16'hC44D};

    btnu = 1'b1; cmd_valid = 1'b0; clr_req = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_operand = '0;
    step(2);
    btnu = 1'b0;

    chk("rst_count", fifo_count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res", {res_valid, res_data}, 0);
    chk("rst_outs", {out_btnl, out_btnc, out_btnr, out_btnd, out_btnu, out_sw}, 0);

    // Single command with exact latency.
    push_cmd(3'b011, 16'h1234);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      bd[k] = out_btnd;
      rv[k] = res_valid;
    end
    for (int k = 1; k <= 6; k++) chk($sformatf("t1_btnd_n%0d", k), bd[k], (k == 3));
    chk("t1_rv_n5", rv[5], 0);
    chk("t1_rv_n6", rv[6], 1);
    step(1);
    chk("t1_lcr", {out_btnl, out_btnc, out_btnr}, 3'b011);
    chk("t1_sw", out_sw, 16'h1234);
    chk("t1_res", res_data, 16'h5678);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    chk("t1_rv_clr", res_valid, 0);
    chk("t1_idle", busy, 0);

    // Vector table.
    for (int i = 0; i < 4; i++) begin
      push_cmd(vecs[i].op, vecs[i].opd);
      wait_rv(1, $sformatf("vec%0d_rv", i));
      chk($sformatf("vec%0d_lcr", i), {out_btnl, out_btnc, out_btnr}, vecs[i].lcr);
      chk($sformatf("vec%0d_sw", i), out_sw, vecs[i].opd);
      chk($sformatf("vec%0d_res", i), res_data, vecs[i].res);
      res_ready = 1'b1;
      step(1);
      res_ready = 1'b0;
    end

    // Full FIFO behind a stalled result.
    push_cmd(3'b001, 16'h0000);
    wait_rv(1, "full_rv");
    held = res_data;
    n0 = n_res;
    nb0 = n_btnd;
    for (int j = 1; j <= 4; j++) push_cmd(3'b010, 16'(j));
    chk("full_count", fifo_count, 4);
    chk("full_ready", cmd_ready, 0);
    cmd_op = 3'b010; cmd_operand = 16'h0005; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    chk("full_refuse", fifo_count, 4);
    step(5);
    chk("bp_res_stable", res_data, held);
    chk("bp_rv", res_valid, 1);
    chk("bp_no_strobe", n_btnd - nb0, 0);
    res_ready = 1'b1;
    t = 0;
    while (res_q.size() != 0 && t < 300) begin
      step(1);
      t++;
    end
    step(20);
    chk("full_results", n_res - n0, 5);
    chk("full_drained", {fifo_count, busy}, 0);
    chk("full_cmdq", cmd_q.size(), 0);

    // Clear requested during HOLD of A with B queued.
    push_cmd(3'b100, 16'h00AA);
    push_cmd(3'b110, 16'h00BB);
    wait_strobe("clr_strobe_a");
    step(1);
    clr_req = 1'b1;
    step(2);
    clr_req = 1'b0;
    rc = -1; uc = -1; dc = -1; nu = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid && res_ready && rc < 0) rc = c;
      if (out_btnu) begin
        nu++;
        if (uc < 0) uc = c;
      end
      if (out_btnd && dc < 0) dc = c;
    end
    chk("clr_once", nu, 1);
    chk("clr_after_a", (rc >= 0) && (uc > rc), 1);
    chk("clr_then_b", dc - uc, 4);
    step(10);

    // Reset during STROBE with two queued; same-edge push/clear ignored.
    push_cmd(3'b001, 16'h0C01);
    push_cmd(3'b001, 16'h0C02);
    push_cmd(3'b001, 16'h0C03);
    wait_strobe("rst_strobe");
    btnu = 1'b1; cmd_valid = 1'b1; cmd_op = 3'b111; cmd_operand = 16'hFFFF; clr_req = 1'b1;
    @(posedge clk);
    #1;
    btnu = 1'b0; cmd_valid = 1'b0; clr_req = 1'b0;
    cmd_q.delete();
    res_q.delete();
    chk("mid_rst_outs", {out_btnl, out_btnc, out_btnr, out_btnd, out_btnu, out_sw}, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res", {res_valid, res_data}, 0);
    nb0 = n_btnd;
    nu0 = n_btnu;
    step(30);
    chk("mid_rst_no_btnd", n_btnd - nb0, 0);
    chk("mid_rst_no_btnu", n_btnu - nu0, 0);
    chk("mid_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
